eeg_pea_out_wb: RTL and testbench

Output write-back collector placed directly downstream of the PE array engine. It accepts the per-PE output streams (valid/last/ready, data, ORAM address), arbitrates them round-robin onto a single registered ORAM write port, and tracks per-PE completion. It raises a one-cycle DONE when every PE has delivered its last beat and the write port has drained.

---
 rtl/eeg_pea_out_wb.sv | 152 +++++++++++++++
 tb/tb_eeg_pea_out_wb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeg_pea_out_wb.sv
// Output write-back collector: round-robin merge of PE output streams onto one
// registered ORAM write port, with per-channel completion tracking and a DONE pulse.
module eeg_pea_out_wb #(
    parameter int unsigned PE_ROW      = 4,
    parameter int unsigned PE_COL      = 4,
    parameter int unsigned PE_OUT_DW   = 8,
    parameter int unsigned ORAM_ADD_AW = 8,
    parameter int unsigned CNT_DW      = 16,
    localparam int unsigned N          = PE_ROW * PE_COL,
    localparam int unsigned IW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       START,
    output logic                       IS_IDLE,
    output logic                       DONE,
    output logic [CNT_DW-1:0]          WR_CNT,
    input  logic [N-1:0]               PE_VLD,
    input  logic [N-1:0]               PE_LST,
    output logic [N-1:0]               PE_RDY,
    input  logic [N*PE_OUT_DW-1:0]     PE_DAT,
    input  logic [N*ORAM_ADD_AW-1:0]   PE_ADD,
    output logic                       ORAM_WEN,
    input  logic                       ORAM_RDY,
    output logic [IW-1:0]              ORAM_IDX,
    output logic [ORAM_ADD_AW-1:0]     ORAM_ADD,
    output logic [PE_OUT_DW-1:0]       ORAM_DAT
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_full;
    logic [IW-1:0]          r_idx;
    logic [ORAM_ADD_AW-1:0] r_add;
    logic [PE_OUT_DW-1:0]   r_dat;
    logic [IW-1:0]          r_ptr;
    logic [N-1:0]           r_done_mask;
    logic [CNT_DW-1:0]      r_wr_cnt;

    logic [N-1:0]           w_elig;
    logic                   w_any;
    logic [IW-1:0]          w_g;
    int unsigned            w_arb_j;
    logic                   w_can_load;
    logic                   w_acc;
    logic                   w_wr;
    logic                   w_start;
    logic [IW-1:0]          w_ptr_nxt;
    logic [N-1:0]           w_done_nxt;
    logic [ORAM_ADD_AW-1:0] w_sel_add;
    logic [PE_OUT_DW-1:0]   w_sel_dat;

    assign w_elig     = PE_VLD & ~r_done_mask & {N{r_state == StRun}};
    assign w_can_load = !r_full || ORAM_RDY;
    assign w_acc      = w_any && w_can_load;
    assign w_wr       = r_full && ORAM_RDY;
    assign w_start    = (r_state == StIdle) && START;

    // First eligible channel at or above the pointer, wrapping past N-1.
    always_comb begin
        w_any   = 1'b0;
        w_g     = '0;
        w_arb_j = 0;
        for (int unsigned i = 0; i < N; i++) begin
            w_arb_j = (32'(r_ptr) + i) % N;
            if (!w_any && w_elig[w_arb_j]) begin
                w_any = 1'b1;
                w_g   = IW'(w_arb_j);
            end
        end
    end

    always_comb begin
        PE_RDY = '0;
        if (w_any) begin
            PE_RDY[w_g] = w_can_load;
        end
    end

    assign w_sel_add = PE_ADD[32'(w_g)*ORAM_ADD_AW +: ORAM_ADD_AW];
    assign w_sel_dat = PE_DAT[32'(w_g)*PE_OUT_DW +: PE_OUT_DW];
    assign w_ptr_nxt = (32'(w_g) == N - 1) ? '0 : w_g + 1'b1;

    always_comb begin
        w_done_nxt = r_done_mask;
        if (w_acc && PE_LST[w_g]) begin
            w_done_nxt[w_g] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (START) w_state_nxt = StRun;
            StRun:   if (&w_done_nxt) w_state_nxt = StDrain;
            StDrain: if (!r_full) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_full      <= 1'b0;
            r_idx       <= '0;
            r_add       <= '0;
            r_dat       <= '0;
            r_ptr       <= '0;
            r_done_mask <= '0;
            r_wr_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_done_mask <= '0;
                r_wr_cnt    <= '0;
                r_ptr       <= '0;
            end else begin
                if (w_acc) begin
                    r_ptr       <= w_ptr_nxt;
                    r_done_mask <= w_done_nxt;
                end
                if (w_wr && (r_wr_cnt != '1)) begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
            // A reload on the same cycle as a drain keeps the register full.
            if (w_acc) begin
                r_full <= 1'b1;
                r_idx  <= w_g;
                r_add  <= w_sel_add;
                r_dat  <= w_sel_dat;
            end else if (ORAM_RDY) begin
                r_full <= 1'b0;
            end
        end
    end

    assign IS_IDLE  = (r_state == StIdle);
    assign DONE     = (r_state == StDrain) && !r_full;
    assign WR_CNT   = r_wr_cnt;
    assign ORAM_WEN = r_full;
    assign ORAM_IDX = r_idx;
    assign ORAM_ADD = r_add;
    assign ORAM_DAT = r_dat;

endmodule

// File: tb/tb_eeg_pea_out_wb.sv
// Directed bench for eeg_pea_out_wb: per-channel beat sources, an ORAM write log
// compared against hand-built channel orders, and a 4-bit-counter twin for saturation.
module tb_eeg_pea_out_wb;

    localparam int N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           START;
    logic           ORAM_RDY;
    logic [N-1:0]   PE_VLD;
    logic [N-1:0]   PE_LST;
    logic [N*8-1:0] PE_DAT;
    logic [N*8-1:0] PE_ADD;

    logic           is_idle, done, oram_wen;
    logic [15:0]    wr_cnt;
    logic [N-1:0]   pe_rdy;
    logic [3:0]     oram_idx;
    logic [7:0]     oram_add, oram_dat;

    logic           is_idle2, done2, oram_wen2;
    logic [3:0]     wr_cnt2;
    logic [N-1:0]   pe_rdy2;
    logic [3:0]     oram_idx2;
    logic [7:0]     oram_add2, oram_dat2;

    eeg_pea_out_wb dut (
        .clk(clk), .rst(rst), .START(START), .IS_IDLE(is_idle), .DONE(done),
        .WR_CNT(wr_cnt), .PE_VLD(PE_VLD), .PE_LST(PE_LST), .PE_RDY(pe_rdy),
        .PE_DAT(PE_DAT), .PE_ADD(PE_ADD), .ORAM_WEN(oram_wen), .ORAM_RDY(ORAM_RDY),
        .ORAM_IDX(oram_idx), .ORAM_ADD(oram_add), .ORAM_DAT(oram_dat)
    );

    eeg_pea_out_wb #(.CNT_DW(4)) dut_sat (
        .clk(clk), .rst(rst), .START(START), .IS_IDLE(is_idle2), .DONE(done2),
        .WR_CNT(wr_cnt2), .PE_VLD(PE_VLD), .PE_LST(PE_LST), .PE_RDY(pe_rdy2),
        .PE_DAT(PE_DAT), .PE_ADD(PE_ADD), .ORAM_WEN(oram_wen2), .ORAM_RDY(ORAM_RDY),
        .ORAM_IDX(oram_idx2), .ORAM_ADD(oram_add2), .ORAM_DAT(oram_dat2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int         cnt [N];
    int         bidx[N];
    int         base[N];
    logic [N-1:0] hold;
    logic       src_en;

    logic [3:0] q_idx[$];
    logic [7:0] q_add[$];
    logic [7:0] q_dat[$];
    int         q_cyc[$];
    int         exp_q[$];
    int         done_cnt, done_cyc, cyc_n, ch3_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            PE_VLD[k]         = src_en && (cnt[k] > 0 || hold[k]);
            PE_LST[k]         = (cnt[k] == 1);
            PE_ADD[k*8 +: 8]  = 8'(base[k] + bidx[k]);
            PE_DAT[k*8 +: 8]  = 8'(k*16 + bidx[k]);
        end
    endtask

    // One clock: sample handshakes mid-cycle, then advance sources after the edge.
    task automatic cyc();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = rst ? '0 : (PE_VLD & pe_rdy);
        if (!rst && oram_wen && ORAM_RDY) begin
            q_idx.push_back(oram_idx);
            q_add.push_back(oram_add);
            q_dat.push_back(oram_dat);
            q_cyc.push_back(cyc_n);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        if (cnt[3] == 0 && hold[3] && pe_rdy[3]) ch3_bad++;
        @(posedge clk);
        #1;
        cyc_n++;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                cnt[k]--;
                bidx[k]++;
            end
        end
        drive();
    endtask

    task automatic setup(input int beats);
        for (int k = 0; k < N; k++) begin
            cnt[k]  = beats;
            bidx[k] = 0;
            base[k] = k * 8;
        end
        hold = '0;
        q_idx.delete(); q_add.delete(); q_dat.delete(); q_cyc.delete(); exp_q.delete();
        done_cnt = 0;
        ch3_bad  = 0;
        drive();
    endtask

    task automatic start_pass();
        START = 1'b1;
        cyc();
        START = 1'b0;
    endtask

    task automatic finish_pass(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) cyc();
        cyc();
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_idle"}, is_idle, 1'b1);
        chk({tag, "_wen_off"}, oram_wen, 1'b0);
    endtask

    task automatic cmp_log(input string tag);
        int b[N];
        int bad;
        int k;
        bad = 0;
        for (int i = 0; i < N; i++) b[i] = 0;
        chk({tag, "_nwr"}, q_idx.size(), exp_q.size());
        for (int i = 0; i < q_idx.size() && i < exp_q.size(); i++) begin
            k = exp_q[i];
            if (q_idx[i] !== 4'(k) || q_add[i] !== 8'(base[k] + b[k]) ||
                q_dat[i] !== 8'(k*16 + b[k])) bad++;
            b[k]++;
        end
        chk({tag, "_seq_bad"}, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] h_idx;
        logic [7:0] h_add, h_dat;
        int held_bad, rdy_bad, n3;

        cyc_n    = 0;
        rst      = 1'b1;
        START    = 1'b0;
        ORAM_RDY = 1'b1;
        src_en   = 1'b1;
        PE_VLD = '0; PE_LST = '0; PE_ADD = '0; PE_DAT = '0;
        setup(1);
        cyc(); cyc();

        // Reset values, with every channel presenting a beat.
        chk("rst_idle",  is_idle, 1'b1);
        chk("rst_done",  done, 1'b0);
        chk("rst_wrcnt", wr_cnt, 0);
        chk("rst_rdy",   pe_rdy, 0);
        chk("rst_wen",   oram_wen, 1'b0);
        chk("rst_idx",   oram_idx, 0);
        chk("rst_add",   oram_add, 0);
        chk("rst_dat",   oram_dat, 0);
        rst = 1'b0;
        cyc();
        chk("idle_no_rdy", pe_rdy, 0);

        // Test 1: channel 5 sends three beats at 0x10.., all others one LST beat.
        setup(1);
        cnt[5]  = 3;
        base[5] = 8'h10;
        drive();
        for (int k = 0; k < N; k++) exp_q.push_back(k);
        exp_q.push_back(5);
        exp_q.push_back(5);
        start_pass();
        finish_pass("t1", 60);
        cmp_log("t1");
        chk("t1_wrcnt", wr_cnt, 18);
        chk("t1_wrcnt_sat4", wr_cnt2, 15);
        chk("t1_done_after_last", done_cyc, q_cyc[$] + 1);
        chk("t1_done_low", done, 1'b0);

        // Test 2: all channels continuously valid, three beats each.
        setup(3);
        for (int i = 0; i < 48; i++) exp_q.push_back(i % N);
        start_pass();
        finish_pass("t2", 100);
        cmp_log("t2");
        chk("t2_one_per_cycle", q_cyc[$] - q_cyc[0], 47);
        chk("t2_wrcnt", wr_cnt, 48);
        chk("t2_wrcnt_sat4", wr_cnt2, 15);

        // Test 3: ORAM stalls for five cycles mid-stream.
        setup(2);
        for (int i = 0; i < 32; i++) exp_q.push_back(i % N);
        start_pass();
        repeat (4) cyc();
        ORAM_RDY = 1'b0;
        #1;
        chk("t3_wen_stall", oram_wen, 1'b1);
        h_idx = oram_idx; h_add = oram_add; h_dat = oram_dat;
        held_bad = 0;
        rdy_bad  = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (oram_wen !== 1'b1 || oram_idx !== h_idx || oram_add !== h_add ||
                oram_dat !== h_dat) held_bad++;
            if (pe_rdy !== '0) rdy_bad++;
            cyc();
        end
        ORAM_RDY = 1'b1;
        chk("t3_held_bad", held_bad, 0);
        chk("t3_rdy_bad", rdy_bad, 0);
        finish_pass("t3", 100);
        cmp_log("t3");
        chk("t3_wrcnt", wr_cnt, 32);

        // Test 4: channel 3 keeps VLD after its only (LST) beat.
        setup(3);
        cnt[3]  = 1;
        hold[3] = 1'b1;
        drive();
        for (int k = 0; k < N; k++) exp_q.push_back(k);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++)
                if (k != 3) exp_q.push_back(k);
        start_pass();
        finish_pass("t4", 100);
        cmp_log("t4");
        n3 = 0;
        foreach (q_idx[i]) if (q_idx[i] == 4'd3) n3++;
        chk("t4_ch3_writes", n3, 1);
        chk("t4_ch3_rdy_after_done", ch3_bad, 0);
        hold = '0;
        drive();

        // Test 5: reset two cycles into RUN with the register full; START during reset.
        setup(2);
        start_pass();
        cyc(); cyc();
        chk("t5_full_before", oram_wen, 1'b1);
        rst   = 1'b1;
        START = 1'b1;
        cyc();
        rst   = 1'b0;
        START = 1'b0;
        #1;
        chk("t5_wen_cleared", oram_wen, 1'b0);
        chk("t5_wrcnt_cleared", wr_cnt, 0);
        chk("t5_idle", is_idle, 1'b1);
        chk("t5_rdy", pe_rdy, 0);
        cyc();
        chk("t5_start_in_rst_ignored", is_idle, 1'b1);
        setup(1);
        for (int k = 0; k < N; k++) exp_q.push_back(k);
        start_pass();
        finish_pass("t5", 60);
        cmp_log("t5");
        chk("t5_wrcnt", wr_cnt, 16);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
